// File: rtl/tdm_demux_pkg.sv
// Shared types and frame-geometry helpers for the TDM demultiplexer.
// Defining TDM_DEMUX_PARITY_EN adds a trailing even-parity slot to every frame.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int LANES_DEFAULT = 8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Slots per frame: data lanes plus the optional parity slot.
  function automatic int frame_len(input int lanes, input bit parity_en);
    return parity_en ? lanes + 1 : lanes;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index for the TDM frame: advances on each accepted bit, reloads to 1 on sync,
// and flags the bit that completes the frame.
module tdm_slot_counter #(
  parameter int FRAME_LEN = 8,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  output logic [SEL_W-1:0] slot_o,
  output logic             wrap_o
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(FRAME_LEN - 1);

  logic [SEL_W-1:0] slot_q, slot_d;

  // A sync bit occupies slot 0, so the counter lands on 1 and never wraps that cycle.
  always_comb begin
    slot_d = slot_q;
    wrap_o = 1'b0;
    if (en_i) begin
      if (sync_i) begin
        slot_d = SEL_W'(1);
      end else if (slot_q == LAST_SLOT) begin
        slot_d = '0;
        wrap_o = 1'b1;
      end else begin
        slot_d = slot_q + SEL_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_1_8.sv
// Serial TDM receiver: steers one bit per slot into an assembly register and hands complete
// frames to a single-entry valid/ready output buffer. TDM_DEMUX_PARITY_EN enables out_perr.
module tdm_demux_1_8
  import tdm_demux_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int SEL_W = $clog2(frame_len(LANES, PARITY_EN))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic             out_perr,
  output logic [SEL_W-1:0] out_sel,
  output logic             overrun,
  output logic             sync_err
);

  localparam int FRAME_LEN = frame_len(LANES, PARITY_EN);

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] asm_q, asm_d;
  logic [FRAME_LEN-1:0] frame;
  logic [LANES-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_perr_q, out_perr_d;
  logic                 overrun_q, overrun_d;
  logic                 sync_err_q, sync_err_d;
  logic                 slot_en;
  logic                 wrap;
  logic                 load;
  logic [SEL_W-1:0]     slot;

  // While hunting, only a sync-marked bit may start the counter.
  assign slot_en = in_valid & (in_sync | (state_q == COLLECT));

  tdm_slot_counter #(
    .FRAME_LEN(FRAME_LEN),
    .SEL_W    (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .en_i  (slot_en),
    .sync_i(in_sync),
    .slot_o(slot),
    .wrap_o(wrap)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == HUNT && in_valid && in_sync) begin
      state_d = COLLECT;
    end
  end

  always_comb begin
    frame = asm_q;
    if (slot_en) begin
      if (in_sync) begin
        frame    = '0;
        frame[0] = in_bit;
      end else begin
        frame[slot] = in_bit;
      end
    end
    asm_d = wrap ? '0 : frame;

    // The buffer accepts a new word when empty or when it is being drained this same cycle.
    load        = wrap & (~out_valid_q | out_ready);
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    out_data_d = load ? frame[LANES-1:0] : out_data_q;
`ifdef TDM_DEMUX_PARITY_EN
    out_perr_d = load ? ^frame : out_perr_q;
`else
    out_perr_d = 1'b0;
`endif
    overrun_d  = wrap & ~load;
    sync_err_d = in_valid & in_sync & (state_q == COLLECT) & (slot != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_perr_q  <= out_perr_d;
      overrun_q   <= overrun_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_perr  = out_perr_q;
  assign out_sel   = slot;
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Self-checking bench for tdm_demux_1_8: directed frame scenarios followed by random traffic,
// all compared against a queue-based frame model.
module tb_tdm_demux_1_8;

  localparam int LANES = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME = LANES + 1;
`else
  localparam int FRAME = LANES;
`endif
  localparam int SEL_W = $clog2(FRAME);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_bit, in_sync, out_ready;
  logic             out_valid, out_perr, overrun, sync_err;
  logic [LANES-1:0] out_data;
  logic [SEL_W-1:0] out_sel;

  tdm_demux_1_8 #(.LANES(LANES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_sync  (in_sync),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_perr (out_perr),
    .out_sel  (out_sel),
    .overrun  (overrun),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bits gathered since the frame start, plus the expected output buffer.
  logic             m_hunt;
  logic             m_bits[$];
  logic             exp_valid, exp_perr, exp_overrun, exp_serr;
  logic [LANES-1:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hunt      = 1'b1;
    m_bits.delete();
    exp_valid   = 1'b0;
    exp_perr    = 1'b0;
    exp_overrun = 1'b0;
    exp_serr    = 1'b0;
    exp_data    = '0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic b, input logic r);
    logic             complete;
    logic             par;
    logic [LANES-1:0] word;
    complete    = 1'b0;
    par         = 1'b0;
    word        = '0;
    exp_overrun = 1'b0;
    exp_serr    = 1'b0;
    if (v) begin
      if (s) begin
        if (!m_hunt && m_bits.size() != 0) exp_serr = 1'b1;
        m_bits.delete();
        m_bits.push_back(b);
        m_hunt = 1'b0;
      end else if (!m_hunt) begin
        m_bits.push_back(b);
      end
      if (m_bits.size() == FRAME) begin
        complete = 1'b1;
        for (int i = 0; i < FRAME; i++) par ^= m_bits[i];
        for (int i = 0; i < LANES; i++) word[i] = m_bits[i];
        m_bits.delete();
      end
    end
    if (complete && (!exp_valid || r)) begin
      exp_valid = 1'b1;
      exp_data  = word;
`ifdef TDM_DEMUX_PARITY_EN
      exp_perr  = par;
`else
      exp_perr  = 1'b0;
`endif
    end else if (complete) begin
      exp_overrun = 1'b1;
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, exp_valid);
    check("out_data", out_data, exp_data);
    check("out_perr", out_perr, exp_perr);
    check("out_sel", out_sel, m_bits.size());
    check("overrun", overrun, exp_overrun);
    check("sync_err", sync_err, exp_serr);
  endtask

  // Called at a falling edge: drive, advance the model, then check at the next falling edge.
  task automatic cycle(input logic v, input logic s, input logic b, input logic r);
    in_valid  = v;
    in_sync   = s;
    in_bit    = b;
    out_ready = r;
    model_step(v, s, b, r);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_frame(input logic [7:0] w, input logic sync, input logic par,
                            input logic r_body, input logic r_last);
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b1, sync && (i == 0), (i < LANES) ? w[i] : par, (i == FRAME - 1) ? r_last : r_body);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Unsynced traffic in HUNT is ignored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("hunt_sel", out_sel, 0);
    check("hunt_valid", out_valid, 0);

    // First synced frame, consumer always ready.
    send_frame(8'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
    check("f4d_data", out_data, 8'h4D);
    check("f4d_valid", out_valid, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("f4d_drop", out_valid, 0);

    // Back-to-back frames with a stalled consumer: second one overruns.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a5_data", out_data, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", overrun, 1);
    check("ovr_hold", out_data, 8'hA5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_once", overrun, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_valid", out_valid, 0);
    check("drain_data", out_data, 8'hA5);

    // Drain and load in the same cycle.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    check("swap_valid", out_valid, 1);
    check("swap_data", out_data, 8'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Sync at slot 3 discards the partial frame.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("serr_pulse", sync_err, 1);
    for (int i = 1; i < FRAME; i++) cycle(1'b1, 1'b0, (i < LANES) ? 1'b1 : 1'b0, 1'b1);
    check("serr_frame", out_data, 8'hFF);
    check("serr_once", sync_err, 0);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(8'h4D, 1'b0, 1'b0, 1'b1, 1'b1);
    check("perr_ok", out_perr, 0);
    send_frame(8'h4D, 1'b0, 1'b1, 1'b1, 1'b1);
    check("perr_bad", out_perr, 1);
`endif

    // Reset mid-frame with a full output buffer.
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_rst_hunt", out_valid, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
    check("post_rst_frame", out_data, 8'h81);

    // Random traffic: stalls, occasional resyncs, bursty consumer.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 40) == 0, 1'($urandom), ($urandom % 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
